// File: rtl/redirect_ctrl_if.sv
// Front-end redirect bundle: retire/decode requests in, PC-generator strobes and squash controls out.
interface redirect_ctrl_if;
  logic        mispred_vld_rt_i;
  logic [63:0] mispred_pc_rt_i;
  logic        exc_vld_rt_i;
  logic [63:0] exc_vec_rt_i;
  logic        override_req_d_i;
  logic [63:0] override_pc_d_i;
  logic        flush_vld_rt_o;
  logic [63:0] flush_pc_rt_o;
  logic        override_vld_f1_o;
  logic [63:0] override_pc_f1_o;
  logic [10:0] kill_o;
  logic        fetch_hold_o;
  logic        busy_o;

  modport slave (
    input  mispred_vld_rt_i, mispred_pc_rt_i, exc_vld_rt_i, exc_vec_rt_i,
           override_req_d_i, override_pc_d_i,
    output flush_vld_rt_o, flush_pc_rt_o, override_vld_f1_o, override_pc_f1_o,
           kill_o, fetch_hold_o, busy_o
  );

  modport master (
    output mispred_vld_rt_i, mispred_pc_rt_i, exc_vld_rt_i, exc_vec_rt_i,
           override_req_d_i, override_pc_d_i,
    input  flush_vld_rt_o, flush_pc_rt_o, override_vld_f1_o, override_pc_f1_o,
           kill_o, fetch_hold_o, busy_o
  );
endinterface

// File: rtl/redirect_ctrl.sv
// Redirect controller: turns retire flushes and decode overrides into PC-generator strobes,
// squash masks and a post-flush fetch hold. Optional exception path: REDIRECT_EXC_EN.
module redirect_ctrl #(
  parameter int unsigned DRAIN_CYC = 3
) (
  input logic            clock,
  input logic            reset_n,
  redirect_ctrl_if.slave bus
);

  localparam int unsigned PC_W   = 64;
  localparam int unsigned KILL_W = 11;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                flush_vld;
  logic [PC_W-1:0]     flush_pc;
  logic                ovr_vld;
  logic [PC_W-1:0]     ovr_pc;
  logic [KILL_W-1:0]   kill;
  logic                hold;
  logic                busy;

  logic                flush_req;
  logic [PC_W-1:0]     flush_tgt;

  // Exception vector has priority over the mispredict target when both retire together.
`ifdef REDIRECT_EXC_EN
  assign flush_req = bus.mispred_vld_rt_i | bus.exc_vld_rt_i;
  assign flush_tgt = bus.exc_vld_rt_i ? bus.exc_vec_rt_i : bus.mispred_pc_rt_i;
`else
  logic unused_exc;
  assign unused_exc = ^{bus.exc_vld_rt_i, bus.exc_vec_rt_i};
  assign flush_req  = bus.mispred_vld_rt_i;
  assign flush_tgt  = bus.mispred_pc_rt_i;
`endif

  // Redirect FSM; every output is a register updated alongside the state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      flush_vld <= 1'b0;
      flush_pc  <= '0;
      ovr_vld   <= 1'b0;
      ovr_pc    <= '0;
      kill      <= '0;
      hold      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      flush_vld <= 1'b0;
      ovr_vld   <= 1'b0;
      kill      <= '0;
      if (flush_req) begin
        // A flush from any state restarts the redirect; the latest target wins.
        state     <= FLUSH;
        cnt       <= '0;
        flush_vld <= 1'b1;
        flush_pc  <= {flush_tgt[PC_W-1:2], 2'b00};
        kill      <= KILL_W'(11'h7FF);
        hold      <= 1'b0;
        busy      <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            hold <= 1'b0;
            busy <= 1'b0;
            if (bus.override_req_d_i) begin
              ovr_vld <= 1'b1;
              ovr_pc  <= {bus.override_pc_d_i[PC_W-1:2], 2'b00};
              kill    <= KILL_W'(11'h003);
            end
          end
          FLUSH: begin
            state <= DRAIN;
            cnt   <= CNT_W'(DRAIN_CYC - 1);
            hold  <= 1'b1;
            busy  <= 1'b1;
          end
          DRAIN: begin
            if (cnt == '0) begin
              state <= IDLE;
              hold  <= 1'b0;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            hold  <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.flush_vld_rt_o    = flush_vld;
  assign bus.flush_pc_rt_o     = flush_pc;
  assign bus.override_vld_f1_o = ovr_vld;
  assign bus.override_pc_f1_o  = ovr_pc;
  assign bus.kill_o            = kill;
  assign bus.fetch_hold_o      = hold;
  assign bus.busy_o            = busy;

endmodule

// File: tb/tb_redirect_ctrl.sv
// Scoreboard bench for redirect_ctrl: a cycle-age reference model queues expected outputs,
// a monitor compares them on the falling edge.
module tb_redirect_ctrl;

  localparam int DRAIN = 3;
`ifdef REDIRECT_EXC_EN
  localparam bit EXC = 1'b1;
`else
  localparam bit EXC = 1'b0;
`endif

  bit   clock;
  logic reset_n;
  redirect_ctrl_if bus();

  redirect_ctrl #(.DRAIN_CYC(DRAIN)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        fv;
    logic [63:0] fpc;
    logic        ov;
    logic [63:0] opc;
    logic [10:0] kill;
    logic        hold;
    logic        busy;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
  endtask

  // Reference model: age counts cycles since the last accepted flush (-1 = none pending).
  initial begin : model
    int          age;
    logic        req;
    logic [63:0] tgt;
    exp_t        e;
    age = -1;
    forever begin
      @(posedge clock);
      e = '{fv: 1'b0, fpc: '0, ov: 1'b0, opc: '0, kill: '0, hold: 1'b0, busy: 1'b0};
      if (!reset_n) begin
        age = -1;
      end else begin
        req = bus.mispred_vld_rt_i | (EXC & bus.exc_vld_rt_i);
        tgt = (EXC && bus.exc_vld_rt_i) ? bus.exc_vec_rt_i : bus.mispred_pc_rt_i;
        if (req) begin
          age    = 0;
          e.fv   = 1'b1;
          e.fpc  = tgt & ~64'h3;
          e.kill = 11'h7FF;
          e.busy = 1'b1;
        end else if (age >= 0) begin
          age = age + 1;
          if (age <= DRAIN) begin
            e.hold = 1'b1;
            e.busy = 1'b1;
          end else begin
            age = -1;
          end
        end else if (bus.override_req_d_i) begin
          e.ov   = 1'b1;
          e.opc  = bus.override_pc_d_i & ~64'h3;
          e.kill = 11'h003;
        end
      end
      q.push_back(e);
    end
  end

  // Monitor: every cycle the DUT presents a registered output set.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
      end else begin
        e = q.pop_front();
        chk("flush_vld", 64'(bus.flush_vld_rt_o), 64'(e.fv));
        chk("override_vld", 64'(bus.override_vld_f1_o), 64'(e.ov));
        chk("kill", 64'(bus.kill_o), 64'(e.kill));
        chk("fetch_hold", 64'(bus.fetch_hold_o), 64'(e.hold));
        chk("busy", 64'(bus.busy_o), 64'(e.busy));
        if (e.fv) chk("flush_pc", bus.flush_pc_rt_o, e.fpc);
        if (e.ov) chk("override_pc", bus.override_pc_f1_o, e.opc);
        chk("strobe_exclusive", 64'(bus.flush_vld_rt_o & bus.override_vld_f1_o), 64'd0);
      end
    end
  end

  task automatic drive(input logic mis, input logic [63:0] mpc, input logic exc,
                       input logic [63:0] evec, input logic ov, input logic [63:0] opc);
    @(negedge clock);
    bus.mispred_vld_rt_i = mis;
    bus.mispred_pc_rt_i  = mpc;
    bus.exc_vld_rt_i     = exc;
    bus.exc_vec_rt_i     = evec;
    bus.override_req_d_i = ov;
    bus.override_pc_d_i  = opc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
  endtask

  initial begin : stim
    reset_n              = 1'b0;
    bus.mispred_vld_rt_i = 1'b0;
    bus.mispred_pc_rt_i  = '0;
    bus.exc_vld_rt_i     = 1'b0;
    bus.exc_vec_rt_i     = '0;
    bus.override_req_d_i = 1'b0;
    bus.override_pc_d_i  = '0;
    idle(2);
    reset_n = 1'b1;
    idle(2);

    drive(1'b1, 64'h1000_0043, 1'b0, 64'h0, 1'b0, 64'h0);
    idle(6);

    drive(1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 64'h2000);
    idle(1);
    drive(1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 64'h2005);
    drive(1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 64'h200A);
    idle(1);

    // Flush beats a same-cycle override; an override inside the drain is dropped;
    // a mispredict at drain count 1 restarts the whole sequence.
    drive(1'b1, 64'h3000, 1'b0, 64'h0, 1'b1, 64'h4000);
    drive(1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 64'h4400);
    idle(1);
    drive(1'b1, 64'h5000, 1'b0, 64'h0, 1'b0, 64'h0);
    idle(6);

    drive(1'b1, 64'h6000, 1'b1, 64'h8000, 1'b0, 64'h0);
    idle(6);

    drive(1'b0, 64'h0, 1'b1, 64'h9002, 1'b0, 64'h0);
    idle(6);

    // Asynchronous reset in the middle of a drain.
    drive(1'b1, 64'h7000, 1'b0, 64'h0, 1'b0, 64'h0);
    idle(2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_flush_vld", 64'(bus.flush_vld_rt_o), 64'd0);
    chk("rst_flush_pc", bus.flush_pc_rt_o, 64'd0);
    chk("rst_override_vld", 64'(bus.override_vld_f1_o), 64'd0);
    chk("rst_override_pc", bus.override_pc_f1_o, 64'd0);
    chk("rst_kill", 64'(bus.kill_o), 64'd0);
    chk("rst_fetch_hold", 64'(bus.fetch_hold_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    idle(2);
    reset_n = 1'b1;
    idle(4);

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 7) == 0), {$urandom, $urandom},
            ($urandom_range(0, 7) == 0), {$urandom, $urandom},
            ($urandom_range(0, 2) == 0), {$urandom, $urandom});
    end
    idle(8);

    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/redirect_ctrl.md
REDIRECT_CTRL -- requirements
Module: redirect_ctrl

Interface
REQ-001 Parameter: DRAIN_CYC, 3, number of fetch-hold cycles after a flush (legal 1..15).
REQ-002 Port: clock  input  1  pipeline clock, all state updates on rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: mispred_vld_rt_i  input  1  retire-stage branch mispredict.
REQ-005 Port: mispred_pc_rt_i  input  64  correct target of the mispredicted branch.
REQ-006 Port: exc_vld_rt_i  input  1  retire-stage exception (used only with REDIRECT_EXC_EN).
REQ-007 Port: exc_vec_rt_i  input  64  exception handler vector (used only with REDIRECT_EXC_EN).
REQ-008 Port: override_req_d_i  input  1  decode-stage predictor override request.
REQ-009 Port: override_pc_d_i  input  64  decode-stage override target.
REQ-010 Port: flush_vld_rt_o  output  1  flush strobe to the PC generator.
REQ-011 Port: flush_pc_rt_o  output  64  flush target to the PC generator.
REQ-012 Port: override_vld_f1_o  output  1  override strobe to the PC generator.
REQ-013 Port: override_pc_f1_o  output  64  override target to the PC generator.
REQ-014 Port: kill_o  output  11  per-stage squash mask; bit i-1 kills pipeline stage s(i), i = 1..11.
REQ-015 Port: fetch_hold_o  output  1  fetch stall during drain.
REQ-016 Port: busy_o  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, FLUSH, DRAIN; all outputs SHALL be registered.
REQ-018 Flush request = mispred_vld_rt_i, OR'd with exc_vld_rt_i when REDIRECT_EXC_EN is defined; exception target wins over mispredict target when both are high.
REQ-019 IDLE + flush request at edge N: state FLUSH; flush_vld_rt_o=1, kill_o=11'h7FF, flush_pc_rt_o=target with bits [1:0] forced to 0, all visible after edge N (1-cycle latency).
REQ-020 FLUSH always lasts exactly one cycle, then DRAIN with the drain counter loaded to DRAIN_CYC-1; flush_vld_rt_o and kill_o return to 0.
REQ-021 In DRAIN, fetch_hold_o=1; the counter decrements each cycle, and at count 0 the next state is IDLE and fetch_hold_o drops on the same edge.
REQ-022 A flush request in FLUSH or DRAIN SHALL re-enter FLUSH with the new target and restart the drain count; the last request wins.
REQ-023 IDLE + override_req_d_i + no flush request: override_vld_f1_o=1 and override_pc_f1_o=override_pc_d_i with [1:0] forced to 0 for one cycle; kill_o=11'h003 (s1,s2) for that cycle; state stays IDLE.
REQ-024 Flush and override in the same cycle: the flush is taken and the override is dropped, never queued.
REQ-025 An override during FLUSH or DRAIN SHALL be ignored.
REQ-026 flush_vld_rt_o and override_vld_f1_o SHALL never be high in the same cycle.
REQ-027 Back-to-back overrides in IDLE SHALL each produce a one-cycle strobe.

Reset
REQ-028 reset_n low SHALL immediately force state IDLE and the counter to 0; all outputs go to 0, including 64-bit PCs and kill_o.
REQ-029 Reset mid-FLUSH or mid-DRAIN abandons the redirect; after release the block idles until a new request arrives.

Configuration
REQ-030 Macro REDIRECT_EXC_EN: when defined, the exception path per REQ-018 is active; when undefined, exc_vld_rt_i and exc_vec_rt_i are ignored and only mispredict flushes occur.

Verification
REQ-031 Mispredict pulse, pc 0x1000_0043 -> next cycle flush_vld=1, flush_pc=0x1000_0040, kill=0x7FF; fetch_hold=1 for 3 cycles; busy=0 after 4 cycles.
REQ-032 Override pulse, pc 0x2000 in IDLE -> next cycle override_vld=1, pc 0x2000, kill=0x003, state IDLE.
REQ-033 Mispredict (0x3000) and override (0x4000) in the same cycle -> only flush_vld with 0x3000; override_vld stays 0.
REQ-034 Second mispredict (0x5000) during DRAIN count 1 -> FLUSH again with 0x5000; a full 3-cycle drain restarts.
REQ-035 With REDIRECT_EXC_EN, exception vec 0x8000 + mispredict 0x6000 -> flush_pc=0x8000; without the macro -> 0x6000.
REQ-036 reset_n low during DRAIN -> all outputs 0 immediately; busy=0 after release.
